tick_slot_arbiter: RTL and testbench
====================================

TICK_SLOT_ARBITER -- requirements
Module: tick_slot_arbiter

Interface
REQ-001 SHALL use parameter NREQ, default 4: number of requesters (power of two, 2..8).
REQ-002 SHALL use parameter LW, default 8: width of slot length and remaining-count fields.
REQ-003 clock  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  one-cycle time-base pulse from the team's free-running tick generator.
REQ-006 enable  input  1  arbitration enable; when low, no new slot is granted.
REQ-007 req  input  NREQ  per-requester request level, held high while the resource is wanted.
REQ-008 slot_len  input  LW  slot length in ticks; 0 is treated as 1.
REQ-009 grant  output  NREQ  one-hot grant; all-zero when idle.
REQ-010 grant_id  output  log2(NREQ)  index of current owner; 0 when idle.
REQ-011 busy  output  1  high while any grant is active.
REQ-012 slot_start  output  1  one-cycle pulse on the first cycle of every new or renewed slot.
REQ-013 remaining  output  LW  ticks left in current slot; 0 when idle.

Function
REQ-014 SHALL implement FSM states IDLE and BUSY.
REQ-015 IDLE -> BUSY when enable=1 and req!=0; grant registered, visible the cycle after the decision (latency 1).
REQ-016 Winner SHALL be chosen round-robin: search starts at (last_owner+1) mod NREQ; last_owner resets to NREQ-1 so requester 0 wins first.
REQ-017 On each grant, remaining SHALL load max(slot_len,1), sampled in the decision cycle; later slot_len changes do not affect the running slot.
REQ-018 In BUSY, each cycle with tick=1 SHALL decrement remaining by 1; a tick in the IDLE decision cycle is not counted.
REQ-019 Expiry: tick=1 with remaining=1 ends the slot; owner excluded from the search unless it is the only requester.
REQ-020 Early release: req[owner]=0 in BUSY ends the slot that cycle, regardless of tick.
REQ-021 On slot end with enable=1 and an eligible requester, SHALL hand over directly BUSY -> BUSY with no idle cycle; grant changes next cycle and slot_start pulses.
REQ-022 On expiry with only the owner requesting, SHALL re-grant the owner, reload remaining, pulse slot_start.
REQ-023 On slot end with no eligible requester or enable=0, SHALL return to IDLE; grant, grant_id, busy, remaining go to 0 next cycle.
REQ-024 enable falling during BUSY SHALL NOT preempt; current slot runs to expiry or release.
REQ-025 Simultaneous expiry and req[owner] drop SHALL be treated as a single slot end (one handover, one slot_start).
REQ-026 grant SHALL always be one-hot or zero; grant_id and busy SHALL be consistent with grant every cycle.
REQ-027 Requesters raising req mid-slot SHALL wait; no preemption for any reason other than reset.

Reset
REQ-028 reset SHALL asynchronously force IDLE, grant=0, grant_id=0, busy=0, slot_start=0, remaining=0, last_owner=NREQ-1.
REQ-029 reset asserted mid-slot SHALL drop grant immediately; after release, arbitration restarts from requester 0 on the first edge.

Structure
REQ-030 Shared package SHALL hold the state encoding (IDLE, BUSY) and default NREQ/LW constants.
REQ-031 SHALL instantiate one combinational sub-module rr_pick (inputs req mask, start index; outputs found, index).
REQ-032 All outputs SHALL be registered.

Verification
REQ-033 slot_len=3, req=0001, tick every 4 cycles -> grant=0001 one cycle after req; re-grant with slot_start after 3 ticks, continuing while req holds.
REQ-034 req=1111, slot_len=2 -> grants in order 0001,0010,0100,1000,0001, each lasting exactly 2 ticks, no idle cycle between.
REQ-035 req=0011, owner 0 drops req mid-slot with remaining=5 -> grant=0010 next cycle, remaining=slot_len, slot_start=1.
REQ-036 slot_len=0 -> every slot lasts exactly 1 tick.
REQ-037 enable 1->0 mid-slot with req=0110 -> current slot completes, then grant=0, busy=0, no further grants until enable=1.
REQ-038 reset pulse mid-slot on owner 2 -> grant=0 asynchronously; after release with req=0100, grant=0100 one cycle later and remaining=slot_len.

Source files
------------

// File: rtl/tick_slot_arbiter_pkg.sv
// Shared definitions for the tick-slot arbiter: FSM encoding and default sizes.
package tick_slot_arbiter_pkg;
  localparam int DEF_NREQ = 4;
  localparam int DEF_LW   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/tick_slot_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of req_mask at or after start, wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_mask,
  input  logic [$clog2(NREQ)-1:0] start,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] index
);
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] cand;

  // Walk from farthest to nearest so the nearest hit is written last; NREQ is a
  // power of two, so the IW-bit add wraps naturally.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = start + IW'(i);
      if (req_mask[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end
endmodule

// File: rtl/tick_slot_arbiter.sv
// Round-robin arbiter granting the resource in slots measured in time-base ticks.
module tick_slot_arbiter
  import tick_slot_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int LW   = DEF_LW
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    enable,
  input  logic [NREQ-1:0]         req,
  input  logic [LW-1:0]           slot_len,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    slot_start,
  output logic [LW-1:0]           remaining
);
  localparam int IW = $clog2(NREQ);

  state_t          state, state_n;
  logic [NREQ-1:0] grant_n;
  logic [IW-1:0]   grant_id_n;
  logic            busy_n, slot_start_n;
  logic [LW-1:0]   remaining_n, load_len;
  logic [IW-1:0]   last_owner, last_owner_n;
  logic            found, decide;
  logic [IW-1:0]   pick;

  // The owner sits last in the search order starting after last_owner, so it
  // only wins again when nobody else is requesting.
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_mask (req),
    .start    (last_owner + IW'(1)),
    .found    (found),
    .index    (pick)
  );

  assign load_len = (slot_len == '0) ? LW'(1) : slot_len;

  always_comb begin
    state_n      = state;
    grant_n      = grant;
    grant_id_n   = grant_id;
    busy_n       = busy;
    slot_start_n = 1'b0;
    remaining_n  = remaining;
    last_owner_n = last_owner;
    decide       = 1'b0;

    case (state)
      IDLE: decide = 1'b1;
      BUSY: begin
        // Release and expiry in the same cycle collapse into one slot end.
        decide = !req[grant_id] || (tick && remaining == LW'(1));
        if (!decide && tick) remaining_n = remaining - LW'(1);
      end
      default: decide = 1'b1;
    endcase

    if (decide) begin
      if (enable && found) begin
        state_n       = BUSY;
        grant_n       = '0;
        grant_n[pick] = 1'b1;
        grant_id_n    = pick;
        busy_n        = 1'b1;
        slot_start_n  = 1'b1;
        remaining_n   = load_len;
        last_owner_n  = pick;
      end else begin
        state_n     = IDLE;
        grant_n     = '0;
        grant_id_n  = '0;
        busy_n      = 1'b0;
        remaining_n = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      slot_start <= 1'b0;
      remaining  <= '0;
      last_owner <= IW'(NREQ - 1);
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      grant_id   <= grant_id_n;
      busy       <= busy_n;
      slot_start <= slot_start_n;
      remaining  <= remaining_n;
      last_owner <= last_owner_n;
    end
  end
endmodule

// File: tb/tb_tick_slot_arbiter.sv
// Directed bench for tick_slot_arbiter with a slot-level reference model checked every cycle.
module tb_tick_slot_arbiter;
  localparam int NREQ = 4;
  localparam int LW   = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            tick = 1'b0;
  logic            enable = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [LW-1:0]   slot_len = '0;
  logic [NREQ-1:0] grant;
  logic [1:0]      grant_id;
  logic            busy, slot_start;
  logic [LW-1:0]   remaining;

  int checks = 0;
  int errors = 0;
  int tick_per = 0;
  int tcnt = 0;

  // Reference model: owner index (-1 = idle), ticks left, last owner, start pulse.
  int m_owner = -1;
  int m_rem = 0;
  int m_last = NREQ - 1;
  bit m_start = 1'b0;

  tick_slot_arbiter #(.NREQ(NREQ), .LW(LW)) dut (
    .clock(clock), .reset(reset), .tick(tick), .enable(enable), .req(req),
    .slot_len(slot_len), .grant(grant), .grant_id(grant_id), .busy(busy),
    .slot_start(slot_start), .remaining(remaining)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    int  len;
    int  pickv;
    int  c;
    bit  expired;
    len     = (slot_len == 0) ? 1 : int'(slot_len);
    pickv   = -1;
    expired = 1'b0;
    m_start = 1'b0;
    if (m_owner >= 0) begin
      if (req[m_owner] && !(tick && m_rem == 1)) begin
        if (tick) m_rem--;
        return;
      end
      expired = req[m_owner];
    end
    if (!enable) begin
      m_owner = -1;
      m_rem   = 0;
      return;
    end
    for (int k = 1; k <= NREQ; k++) begin
      c = (m_last + k) % NREQ;
      if (req[c] && !(expired && c == m_owner)) begin
        pickv = c;
        break;
      end
    end
    if (pickv < 0 && expired) pickv = m_owner;
    if (pickv < 0) begin
      m_owner = -1;
      m_rem   = 0;
    end else begin
      m_owner = pickv;
      m_last  = pickv;
      m_rem   = len;
      m_start = 1'b1;
    end
  endtask

  always @(posedge clock) begin
    int eg, eid;
    if (reset) begin
      m_owner = -1; m_rem = 0; m_last = NREQ - 1; m_start = 1'b0;
    end else begin
      model_step();
    end
    #1;
    eg  = (m_owner < 0) ? 0 : (1 << m_owner);
    eid = (m_owner < 0) ? 0 : m_owner;
    checks++;
    if (int'(grant) != eg || int'(grant_id) != eid || busy != (m_owner >= 0) ||
        slot_start != m_start || int'(remaining) != m_rem) begin
      errors++;
      $display("FAIL model t=%0t actual grant=%b id=%0d busy=%0d start=%0d rem=%0d required grant=%0d id=%0d busy=%0d start=%0d rem=%0d",
               $time, grant, grant_id, busy, slot_start, remaining,
               eg, eid, (m_owner >= 0), m_start, m_rem);
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; req = '0; enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic sample();
    @(posedge clock);
    #2;
  endtask

  initial begin
    int starts, idle_bad, n;
    int exp_seq[5];
    int seq[$];
    bit hit;
    exp_seq = '{1, 2, 4, 8, 1};

    fork
      forever begin
        @(negedge clock);
        tcnt++;
        tick = (tick_per > 0) && (tcnt % tick_per == 0);
      end
    join_none

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_id", grant_id, 0);
    chk("rst_start", slot_start, 0);
    reset = 1'b0;

    // Single requester, periodic re-grant
    @(negedge clock);
    slot_len = 3; tick_per = 4; enable = 1'b1; req = 4'b0001;
    sample();
    chk("single_grant", grant, 1);
    chk("single_start", slot_start, 1);
    chk("single_rem", remaining, 3);
    starts = 1; idle_bad = 0;
    repeat (39) begin
      sample();
      if (slot_start) starts++;
      if (!busy) idle_bad++;
    end
    chk("single_regrants", starts, 4);
    chk("single_idle", idle_bad, 0);
    @(negedge clock) req = '0;
    repeat (4) @(negedge clock);

    // Full rotation
    do_reset();
    slot_len = 2; tick_per = 1; enable = 1'b1; req = 4'b1111;
    idle_bad = 0;
    repeat (10) begin
      sample();
      if (slot_start) seq.push_back(int'(grant));
      if (!busy) idle_bad++;
    end
    chk("rot_count", seq.size(), 5);
    for (int i = 0; i < 5 && i < seq.size(); i++) chk($sformatf("rot_%0d", i), seq[i], exp_seq[i]);
    chk("rot_idle", idle_bad, 0);

    // Early release mid-slot
    do_reset();
    slot_len = 9; tick_per = 2; enable = 1'b1; req = 4'b0011;
    hit = 1'b0; n = 0;
    while (!hit && n < 40) begin
      sample();
      hit = (remaining == 5) && (grant == 4'b0001);
      n++;
    end
    chk("rel_wait", hit, 1);
    @(negedge clock) req = 4'b0010;
    sample();
    chk("rel_grant", grant, 2);
    chk("rel_rem", remaining, 9);
    chk("rel_start", slot_start, 1);

    // Zero slot length behaves as one tick
    @(negedge clock);
    slot_len = 0; tick_per = 3; req = 4'b0101;
    sample();
    chk("zero_grant", grant, 4);
    chk("zero_rem", remaining, 1);
    repeat (20) @(negedge clock);

    // Enable drop does not preempt
    do_reset();
    slot_len = 4; tick_per = 2; enable = 1'b1; req = 4'b0110;
    sample();
    chk("en_grant", grant, 2);
    @(negedge clock) enable = 1'b0;
    hit = 1'b0; n = 0;
    while (!hit && n < 30) begin
      sample();
      hit = !busy;
      n++;
    end
    chk("en_done", hit, 1);
    chk("en_ran", (n >= 6) ? 1 : 0, 1);
    idle_bad = 0;
    repeat (10) begin
      sample();
      if (busy || grant != 0) idle_bad++;
    end
    chk("en_idle", idle_bad, 0);
    @(negedge clock) enable = 1'b1;
    sample();
    chk("en_resume", grant, 4);

    // Asynchronous reset mid-slot
    do_reset();
    slot_len = 6; tick_per = 2; enable = 1'b1; req = 4'b0100;
    sample();
    chk("ar_grant", grant, 4);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("ar_drop_grant", grant, 0);
    chk("ar_drop_busy", busy, 0);
    @(negedge clock) reset = 1'b0;
    sample();
    chk("ar_regrant", grant, 4);
    chk("ar_rem", remaining, 6);
    chk("ar_start", slot_start, 1);

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
